// File: rtl/tinycpu_pkg.sv
// tinycpu_pkg
//   Types and constants shared by the tinycpu front end (instruction_fetch)
//   and instruction_decoder.
//   - INST_W / ADDR_W      : instruction word and byte-address widths
//   - DEFAULT_RESET_PC     : first fetch address after reset
//   - mem_state_t          : memory-side request FSM encoding
//   - out_state_t          : decoder-side four-phase handshake encoding
//   - fetch_entry_t        : one prefetch buffer entry {pc, inst}
//   - next_pc()            : sequential PC advance with natural 32-bit wrap
package tinycpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        O_IDLE    = 2'd0,
        O_PRESENT = 2'd1,
        O_RELEASE = 2'd2
    } out_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC + 4 lands on 0.
    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] step
    );
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous prefetch FIFO between the memory-side and decoder-side FSMs.
//   Storage is a flop array; head is read straight out of the flop addressed
//   by the read pointer, so it is valid whenever empty=0 with no extra latency.
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high; empties the FIFO
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop head entry (ignored when empty)
//   flush      in   empty the FIFO; overrides push and pop in the same cycle
//   head       out  oldest entry
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of valid entries
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Front stage of the tinycpu pipeline. Walks a PC through instruction
//   memory (one outstanding read at a time), buffers returned words in a
//   prefetch FIFO and hands them to instruction_decoder over a four-phase
//   DOR/ack handshake. A redirect flushes the buffer and restarts fetch at
//   redirect_pc.
// Ports
//   clk            in   clock
//   reset          in   synchronous, active-high
//   enable         in   allows new memory requests (buffer still drains)
//   mem_req        out  read request, held until mem_ack
//   mem_addr       out  request byte address, stable while mem_req=1
//   mem_ack        in   one-cycle pulse, mem_data valid
//   mem_data       in   returned instruction word
//   redirect       in   one-cycle pulse: flush and jump to redirect_pc
//   redirect_pc    in   new PC
//   DOR            out  word ready for decoder
//   data_out       out  instruction word, stable while DOR=1
//   ack_from_next  in   decoder acknowledge (level)
//   pc_out         out  address of data_out
//
// Memory FSM
//   state   | meaning
//   M_IDLE  | no request outstanding; issue when enabled and buffer has room
//   M_WAIT  | mem_req high, waiting for mem_ack
// Output FSM
//   state     | meaning
//   O_IDLE    | nothing presented; pop head when buffer non-empty and ack low
//   O_PRESENT | DOR high, waiting for ack
//   O_RELEASE | DOR low, waiting for ack to return low
module instruction_fetch
    import tinycpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ADDR_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              DOR,
    output logic [INST_W-1:0] data_out,
    input  logic              ack_from_next,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    mem_state_t        mem_state;
    mem_state_t        mem_state_next;
    out_state_t        out_state;
    out_state_t        out_state_next;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic              discard;
    logic [INST_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_out_q;

    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_in;
    fetch_entry_t      fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              issue_ok;
    logic              issue;
    logic              mem_done;

    // Redirect wins over issue: the request in the redirect cycle would use the stale PC.
    assign issue_ok = enable && !redirect && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign mem_done = (mem_state == M_WAIT) && mem_ack;
    assign fifo_in  = '{pc: addr_q, inst: mem_data};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- memory-side FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_state <= M_IDLE;
        end else begin
            mem_state <= mem_state_next;
        end
    end

    always_comb begin
        mem_state_next = mem_state;
        case (mem_state)
            M_IDLE:  if (issue_ok) mem_state_next = M_WAIT;
            M_WAIT:  if (mem_ack)  mem_state_next = M_IDLE;
            default: mem_state_next = M_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (mem_state == M_WAIT);
        issue     = (mem_state == M_IDLE) && issue_ok;
        // A word is dropped if a redirect arrived while it was in flight
        // (discard) or arrives in the very cycle it returns.
        fifo_push = mem_done && !discard && !redirect && !fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            addr_q  <= RESET_PC;
            discard <= 1'b0;
        end else begin
            if (issue) begin
                addr_q <= pc;
            end
            if (redirect) begin
                pc <= redirect_pc;
            end else if (fifo_push) begin
                pc <= next_pc(addr_q, ADDR_STEP);
            end
            if (mem_done) begin
                discard <= 1'b0;
            end else if (redirect && (mem_state == M_WAIT)) begin
                discard <= 1'b1;
            end
        end
    end

    assign mem_addr = addr_q;

    // ---------------- decoder-side FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_state <= O_IDLE;
        end else begin
            out_state <= out_state_next;
        end
    end

    always_comb begin
        out_state_next = out_state;
        case (out_state)
            O_IDLE:    if (!fifo_empty && !ack_from_next) out_state_next = O_PRESENT;
            O_PRESENT: if (ack_from_next)                 out_state_next = O_RELEASE;
            O_RELEASE: if (!ack_from_next)                out_state_next = O_IDLE;
            default:   out_state_next = O_IDLE;
        endcase
    end

    always_comb begin
        DOR      = (out_state == O_PRESENT);
        fifo_pop = (out_state == O_IDLE) && !fifo_empty && !ack_from_next;
    end

    // The presented word lives in its own register, so a flush in the pop
    // cycle (or later) cannot disturb a handshake already under way.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            pc_out_q <= '0;
        end else if (fifo_pop) begin
            data_q   <= fifo_head.inst;
            pc_out_q <= fifo_head.pc;
        end
    end

    assign data_out = data_q;
    assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic        reset, enable, mem_req, mem_ack, redirect, DOR, ack_from_next;
    logic [31:0] mem_addr, mem_data, redirect_pc, data_out, pc_out;
    // wrap-around DUT
    logic        enable2, mem_req2, mem_ack2, redirect2, dor2, ack2;
    logic [31:0] mem_addr2, mem_data2, redirect_pc2, data_out2, pc_out2;

    instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .ADDR_STEP(32'd4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .DOR(DOR), .data_out(data_out), .ack_from_next(ack_from_next), .pc_out(pc_out));

    instruction_fetch #(.RESET_PC(RPC2), .FIFO_DEPTH(4), .ADDR_STEP(32'd4)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack2), .mem_data(mem_data2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .DOR(dor2), .data_out(data_out2), .ack_from_next(ack2), .pc_out(pc_out2));

    int errors = 0;
    int checks = 0;

    // reference model: queue of buffered {pc, word}, next expected fetch address
    logic [63:0] mq[$];
    logic [31:0] exp_pc;
    bit          stale;
    int          run;
    logic [31:0] dlog[$];
    logic [31:0] log2[$];
    int          issue_cnt;
    logic [31:0] last_issue;

    // values driven / observed just before the coming edge
    bit          have_pre = 0;
    logic        p_rst, p_en, p_req, p_ack, p_redir, p_dor, p_ackn;
    logic [31:0] p_addr, p_data, p_rpc, p_dout, p_pcout;
    logic        prev_dor2;

    // stimulus controls
    logic        rst_d, en_d, redir_req, late_ack, dec_stall;
    logic [31:0] redir_tgt;
    int          mem_lat, dec_delay, dec_hold, mcnt, dcnt, hcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic eval_edge();
        logic        issue_exp;
        logic [63:0] hd;
        if (p_rst) begin
            chk("rst_dor", {31'b0, DOR}, 32'd0);
            chk("rst_req", {31'b0, mem_req}, 32'd0);
            chk("rst_addr", mem_addr, 32'h0);
            chk("rst_dout", data_out, 32'h0);
            chk("rst_pcout", pc_out, 32'h0);
            mq.delete(); exp_pc = 32'h0; stale = 0; run = 0;
            return;
        end
        if (p_req) begin
            if (p_ack) chk("req_drop", {31'b0, mem_req}, 32'd0);
            else begin
                chk("req_hold", {31'b0, mem_req}, 32'd1);
                chk("addr_hold", mem_addr, p_addr);
            end
        end else begin
            issue_exp = p_en && !p_redir && (mq.size() < 4);
            chk("req_issue", {31'b0, mem_req}, {31'b0, issue_exp});
            if (mem_req) begin
                chk("issue_addr", mem_addr, exp_pc);
                issue_cnt++;
                last_issue = mem_addr;
            end
        end
        run = (!p_dor && !p_ackn) ? run + 1 : 0;
        if (p_dor) begin
            if (p_ackn) chk("dor_drop", {31'b0, DOR}, 32'd0);
            else begin
                chk("dor_hold", {31'b0, DOR}, 32'd1);
                chk("dout_hold", data_out, p_dout);
                chk("pcout_hold", pc_out, p_pcout);
            end
        end else if (p_ackn) chk("dor_wait_release", {31'b0, DOR}, 32'd0);
        else if (mq.size() == 0) chk("dor_idle_empty", {31'b0, DOR}, 32'd0);
        else if (run >= 2) chk("dor_present", {31'b0, DOR}, 32'd1);
        if (!p_dor && DOR && mq.size() > 0) begin
            hd = mq.pop_front();
            chk("word_pc", pc_out, hd[63:32]);
            chk("word_data", data_out, hd[31:0]);
            dlog.push_back(pc_out);
        end
        if (p_redir) begin
            mq.delete();
            exp_pc = p_rpc;
            if (p_req && !p_ack) stale = 1;
        end else if (p_req && p_ack && !stale) begin
            mq.push_back({p_addr, p_data});
            exp_pc = p_addr + 32'd4;
        end
        if (p_req && p_ack) stale = 0;
    endtask

    task automatic eval_wrap();
        if (!p_rst && !prev_dor2 && dor2) begin
            chk("wrap_data", data_out2, pc_out2 ^ XMASK);
            log2.push_back(pc_out2);
        end
        prev_dor2 = dor2;
    endtask

    task automatic drive_inputs();
        reset = rst_d;
        enable = en_d;
        redirect = redir_req;
        redirect_pc = redir_tgt;
        redir_req = 1'b0;
        if (late_ack) begin
            mem_ack = 1'b1; mem_data = $urandom;
        end else if (mem_req && !mem_ack) begin
            if (mcnt >= mem_lat) begin
                mem_ack = 1'b1; mem_data = mem_addr ^ XMASK; mcnt = 0;
            end else begin
                mem_ack = 1'b0; mcnt++;
            end
        end else begin
            mem_ack = 1'b0; mcnt = 0; mem_data = $urandom;
        end
        if (!ack_from_next) begin
            if (DOR && !dec_stall) begin
                if (dcnt >= dec_delay) begin ack_from_next = 1'b1; dcnt = 0; end
                else dcnt++;
            end else dcnt = 0;
        end else if (!DOR) begin
            if (hcnt >= dec_hold) begin ack_from_next = 1'b0; hcnt = 0; end
            else hcnt++;
        end
        mem_ack2 = mem_req2 && !mem_ack2;
        mem_data2 = mem_addr2 ^ XMASK;
        ack2 = dor2;
        p_rst = reset; p_en = enable; p_req = mem_req; p_addr = mem_addr;
        p_ack = mem_ack; p_data = mem_data; p_redir = redirect; p_rpc = redirect_pc;
        p_dor = DOR; p_dout = data_out; p_pcout = pc_out; p_ackn = ack_from_next;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (have_pre) begin
            eval_edge();
            eval_wrap();
        end
        drive_inputs();
        have_pre = 1;
    endtask

    task automatic do_reset();
        rst_d = 1'b1;
        cycle();
        cycle();
        rst_d = 1'b0;
        dlog.delete(); log2.delete();
        issue_cnt = 0;
    endtask

    initial begin
        int  n0;
        bit  found;
        reset = 1'b1; enable = 1'b0; mem_ack = 1'b0; mem_data = '0; redirect = 1'b0;
        redirect_pc = '0; ack_from_next = 1'b0;
        enable2 = 1'b1; mem_ack2 = 1'b0; mem_data2 = '0; redirect2 = 1'b0; redirect_pc2 = '0; ack2 = 1'b0;
        rst_d = 1'b1; en_d = 1'b0; redir_req = 1'b0; redir_tgt = '0; late_ack = 1'b0; dec_stall = 1'b0;
        mem_lat = 2; dec_delay = 0; dec_hold = 0; mcnt = 0; dcnt = 0; hcnt = 0;
        exp_pc = '0; stale = 0; run = 0; issue_cnt = 0; last_issue = '0; prev_dor2 = 1'b0;
        repeat (2) cycle();

        // in-order delivery, lat 2, quick decoder
        en_d = 1'b1;
        do_reset();
        repeat (60) cycle();
        chk("t1_count", {31'b0, dlog.size() >= 5}, 32'd1);
        chk("t1_pc0", dlog[0], 32'h0);
        chk("t1_pc1", dlog[1], 32'h4);
        chk("t1_pc2", dlog[2], 32'h8);
        // wrap-around instance ran alongside
        chk("t5_pc0", log2[0], 32'hFFFF_FFF8);
        chk("t5_pc1", log2[1], 32'hFFFF_FFFC);
        chk("t5_pc2", log2[2], 32'h0000_0000);

        // stalled decoder: one word presented + FIFO_DEPTH buffered, then no requests
        do_reset();
        dec_stall = 1'b1;
        repeat (40) cycle();
        chk("t2_issues", issue_cnt, 32'd5);
        chk("t2_req_idle", {31'b0, mem_req}, 32'd0);
        chk("t2_dor", {31'b0, DOR}, 32'd1);
        chk("t2_pc_presented", pc_out, 32'h0);
        dec_stall = 1'b0;
        n0 = issue_cnt;
        for (int i = 0; i < 40 && issue_cnt == n0; i++) cycle();
        chk("t2_resume_addr", last_issue, 32'h14);

        // decoder holds ack several cycles
        do_reset();
        dec_hold = 4; dec_delay = 1;
        repeat (80) cycle();
        chk("t3_count", {31'b0, dlog.size() >= 6}, 32'd1);
        for (int i = 0; i < dlog.size(); i++) chk("t3_order", dlog[i], 32'(i * 4));
        dec_hold = 0; dec_delay = 0;

        // redirect while fetch of 0x8 outstanding
        do_reset();
        dec_stall = 1'b1; mem_lat = 5;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (mem_req && mem_addr == 32'h8) found = 1;
        end
        chk("t4_reach", {31'b0, found}, 32'd1);
        redir_tgt = 32'h100; redir_req = 1'b1;
        n0 = issue_cnt;
        cycle();
        for (int i = 0; i < 40 && issue_cnt == n0; i++) cycle();
        chk("t4_next_addr", last_issue, 32'h100);
        chk("t4_dor_kept", {31'b0, DOR}, 32'd1);
        chk("t4_pc_kept", pc_out, 32'h0);
        dec_stall = 1'b0;
        for (int i = 0; i < 120 && dlog.size() < 3; i++) cycle();
        chk("t4_w0", dlog[0], 32'h0);
        chk("t4_w1", dlog[1], 32'h100);
        chk("t4_w2", dlog[2], 32'h104);
        mem_lat = 2;

        // reset during O_PRESENT and M_WAIT, then a late ack
        do_reset();
        dec_stall = 1'b1; mem_lat = 8;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (DOR && mem_req) found = 1;
        end
        chk("t6_reach", {31'b0, found}, 32'd1);
        rst_d = 1'b1;
        cycle();
        rst_d = 1'b0; en_d = 1'b0;
        cycle();
        chk("t6_dor", {31'b0, DOR}, 32'd0);
        chk("t6_req", {31'b0, mem_req}, 32'd0);
        chk("t6_addr", mem_addr, 32'h0);
        late_ack = 1'b1;
        cycle();
        late_ack = 1'b0;
        repeat (5) cycle();
        chk("t6_no_push", {31'b0, DOR}, 32'd0);
        chk("t6_req_after", {31'b0, mem_req}, 32'd0);
        dec_stall = 1'b0; en_d = 1'b1; mem_lat = 2;

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en_d = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                redir_req = 1'b1;
                redir_tgt = $urandom & 32'hFFFF_FFFC;
            end
            mem_lat = $urandom_range(0, 4);
            dec_delay = $urandom_range(0, 3);
            dec_hold = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) dec_stall = !dec_stall;
            cycle();
        end
        chk("rand_progress", {31'b0, dlog.size() > 20}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
